// File: rtl/apb_mem_responder.sv
// rtl/apb_mem_responder.sv - APB completer driving single-cycle strobes to a combinational-read memory
module apb_mem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [WAIT_W-1:0] wait_cycles,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [0:0]        state;
    logic [WAIT_W-1:0] cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic              err_q;

    logic setup;
    logic access;
    logic in_access;
    logic done;
    logic out_of_range;

    assign setup        = psel & ~penable;
    assign access       = psel & penable;
    assign in_access    = (state == ACCESS);
    assign done         = in_access & (cnt == '0);
    assign out_of_range = ({1'b0, paddr} >= DEPTH_L);

    // Outputs are forced low while reset is asserted, independent of the clock.
    assign pready    = ~reset & (in_access ? (cnt == '0) : access);
    assign pslverr   = ~reset & (in_access ? (done & err_q) : access);
    assign mem_wren  = ~reset & done & access & write_q & ~err_q;
    assign mem_rden  = ~reset & done & access & ~write_q & ~err_q;
    assign prdata    = mem_rden ? mem_rdata : '0;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (setup) begin
            // A setup phase in ACCESS restarts the transfer from scratch.
            state   <= ACCESS;
            cnt     <= wait_cycles;
            addr_q  <= paddr;
            wdata_q <= pwdata;
            write_q <= pwrite;
            err_q   <= out_of_range;
        end else if (in_access) begin
            if (!psel) begin
                state <= IDLE;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: doc/apb_mem_responder.md
# apb_mem_responder

APB completer that terminates transfers from the APB master and converts them into single-cycle strobes on the memory bus (`mem_wren`/`mem_rden`) toward a combinational-read register/memory array. A runtime `wait_cycles` value sets how many `pready`-low cycles are inserted before completion. It checks protocol sequencing and address range, and flags errors on `pslverr`.

## Interface
Parameters:
- `ADDR_W`, 8, APB/memory address width
- `DATA_W`, 32, data width
- `DEPTH`, 256, number of valid words; any `paddr >= DEPTH` is out of range
- `WAIT_W`, 4, width of `wait_cycles`

Ports:
- `clk` in 1: single clock; all state changes on the rising edge
- `reset` in 1: asynchronous, active-high
- `psel` in 1: APB select
- `penable` in 1: APB enable (access phase)
- `pwrite` in 1: 1 = write, 0 = read
- `paddr` in ADDR_W: transfer address
- `pwdata` in DATA_W: write data
- `prdata` out DATA_W: read data, valid only while `pready`=1 on a read
- `pready` out 1: completer ready
- `pslverr` out 1: error response, valid only while `pready`=1
- `wait_cycles` in WAIT_W: wait states to insert, sampled in the setup cycle
- `mem_addr` out ADDR_W: latched transfer address
- `mem_wdata` out DATA_W: latched write data
- `mem_wren` out 1: write strobe; the memory commits on the rising edge that ends the strobe cycle
- `mem_rden` out 1: read strobe
- `mem_rdata` in DATA_W: combinational read data for `mem_addr`

## Operation
- State register: IDLE, ACCESS. Registers: `cnt[WAIT_W]`, `addr_q`, `write_q`, `wdata_q`, `err_q`.
- **IDLE, psel=1 and penable=0 (setup) at a clock edge:**
  - Latch `paddr`, `pwrite`, `pwdata` and `cnt <= wait_cycles`.
  - Set `err_q <= (paddr >= DEPTH)`.
  - Go to ACCESS.
- **ACCESS outputs (combinational from registered state):**
  - `pready = (cnt == 0)`.
  - `pslverr = pready & err_q`.
  - `mem_wren = pready & write_q & ~err_q & psel & penable`.
  - `mem_rden`: same, with `~write_q`.
  - `prdata = mem_rden ? mem_rdata : 0`.
- **ACCESS, psel=1 and penable=1, cnt≠0:** `cnt <= cnt-1`, stay in ACCESS.
- **ACCESS, pready=1, psel=1 and penable=1:** transfer completes at this edge; go to IDLE.
- **ACCESS with psel=0 (master abort):** go to IDLE. No strobe was issued and none is issued.
- **ACCESS with psel=1 and penable=0 (setup repeated without an access phase):** treated as a new setup. Re-latch all registers, reload `cnt`, stay in ACCESS.
- **IDLE with psel=1 and penable=1 (access without setup):**
  - Drive `pready=1`, `pslverr=1`, `prdata=0`, no memory strobe.
  - Stay in IDLE.
- **IDLE otherwise:** `pready=0`, `pslverr=0`, `prdata=0`, no strobes.
- `mem_addr=addr_q` and `mem_wdata=wdata_q` at all times. Changes on `paddr`/`pwdata`/`pwrite` after setup are ignored.
- `wait_cycles` is sampled only at setup; changes mid-transfer have no effect.
- **Reset (asynchronous, any time, including mid-transfer):**
  - State IDLE; `cnt`, `addr_q`, `wdata_q`, `write_q`, `err_q` all 0.
  - Outputs go immediately to `pready=0`, `pslverr=0`, `prdata=0`, `mem_wren=0`, `mem_rden=0`, `mem_addr=0`, `mem_wdata=0`.
  - A strobe cut off by reset is not re-issued.

## Timing
- **wait_cycles=N:**
  - Setup cycle, then N ACCESS cycles with `pready=0`, then one ACCESS cycle with `pready=1`.
  - The strobe is asserted only in that final cycle, exactly one cycle wide.
- **wait_cycles=0:** `pready=1` in the first access cycle (2-cycle transfer).
- **Back-to-back:** a new setup in the cycle right after completion is accepted (state is IDLE by then). No idle cycle is required.
- **Read data:** `prdata` is valid in the same cycle as `pready=1`, combinational through `mem_rdata`.
- **Maximum wait:** `wait_cycles = 2^WAIT_W-1` gives 15 waits with defaults. `cnt` never wraps below 0.

## Test plan
- **Zero-wait write:** addr 0x10, data 0xDEADBEEF, wait 0.
  - `pready=1` in the first access cycle.
  - `mem_wren` is high for exactly 1 cycle with `mem_addr=0x10` and `mem_wdata=0xDEADBEEF`.
  - `pslverr=0`.
- **Wait-state read:** memory[0x10]=0xDEADBEEF, wait 5.
  - Exactly 5 access cycles with `pready=0`, then `pready=1`, `prdata=0xDEADBEEF`, `mem_rden` high for 1 cycle.
- **Out-of-range write:** `DEPTH`=200, addr 0xF0, wait 1.
  - `pready` high on the 2nd access cycle with `pslverr=1`, no `mem_wren`, `prdata=0`.
- **Protocol errors:**
  - `psel=1`, `penable=1` from IDLE gives `pready=1` and `pslverr=1` in the same cycle, with no strobe.
  - `psel` dropped after 2 of 3 waits returns to IDLE with no strobe. The next zero-wait write to 0x20 completes normally.
- **Back-to-back with mid-transfer wait change:**
  - Write 0x01 with wait 3, changing `wait_cycles` to 0 during the access phase: still 3 waits.
  - An immediately following read from 0x01 with wait 1 returns 0x01 after 1 wait.
- **Asynchronous reset:** assert `reset` between edges during the final cycle of a wait-3 write.
  - All outputs are 0 immediately; `mem_wren` is never seen at an edge; memory is unchanged.
  - After release, a write with wait 0 works.
